// File: rtl/recurrent_spiking_neuron_if.sv
// Parameter, control and spike bundle for one LIF neuron.
// master drives enable/current/parameters; slave returns spike_out.
interface recurrent_spiking_neuron_if;
  logic       enable;
  logic [7:0] external_input_current;
  logic [7:0] threshold;
  logic [7:0] decay;
  logic [7:0] refractory_period;
  logic [7:0] feedback_scale;
  logic       spike_out;

  modport master (
    output enable,
    output external_input_current,
    output threshold,
    output decay,
    output refractory_period,
    output feedback_scale,
    input  spike_out
  );

  modport slave (
    input  enable,
    input  external_input_current,
    input  threshold,
    input  decay,
    input  refractory_period,
    input  feedback_scale,
    output spike_out
  );
endinterface

// File: rtl/recurrent_spiking_neuron.sv
// Leaky integrate-and-fire neuron with refractory period and self-feedback.
// Ports: clk, reset (sync, active-high), nif (slave: params in, spike_out).
module recurrent_spiking_neuron (
  input logic                        clk,
  input logic                        reset,
  recurrent_spiking_neuron_if.slave  nif
);

  logic [15:0] v_q, v_d;
  logic [7:0]  r_q, r_d;
  logic [7:0]  f_q, f_d;
  logic        spike_q, spike_d;

  logic [16:0] sum;
  logic [15:0] sat;
  logic [15:0] vn;
  logic        fire;

  // 17-bit sum cannot overflow: 0xFFFF + 0xFF + 0xFF < 0x1FFFF.
  always_comb begin
    sum = {1'b0, v_q}
        + {9'd0, nif.external_input_current}
        + {9'd0, f_q};
    sat = sum[16] ? 16'hFFFF : sum[15:0];
    vn  = (sat > {8'd0, nif.decay})
          ? sat - {8'd0, nif.decay}
          : 16'd0;
    fire = (vn >= {8'd0, nif.threshold});
  end

  always_comb begin
    v_d     = v_q;
    r_d     = r_q;
    f_d     = f_q;
    spike_d = 1'b0;
    unique case (1'b1)
      !nif.enable: begin
      end
      nif.enable && (r_q != 8'd0): begin
        r_d = r_q - 8'd1;
        v_d = 16'd0;
      end
      nif.enable && (r_q == 8'd0): begin
        if (fire) begin
          spike_d = 1'b1;
          v_d     = 16'd0;
          r_d     = nif.refractory_period;
          f_d     = nif.feedback_scale;
        end else begin
          v_d = vn;
          f_d = {1'b0, f_q[7:1]};
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q     <= 16'd0;
      r_q     <= 8'd0;
      f_q     <= 8'd0;
      spike_q <= 1'b0;
    end else begin
      v_q     <= v_d;
      r_q     <= r_d;
      f_q     <= f_d;
      spike_q <= spike_d;
    end
  end

  assign nif.spike_out = spike_q;

endmodule

// File: tb/tb_recurrent_spiking_neuron.sv
// Directed bench for recurrent_spiking_neuron.
// Checks spike_out timing against hand-computed spike schedules.
module tb_recurrent_spiking_neuron;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passed = 0;

  recurrent_spiking_neuron_if nif ();

  recurrent_spiking_neuron dut (
    .clk   (clk),
    .reset (reset),
    .nif   (nif.slave)
  );

  always #5 clk = ~clk;

  task automatic tick(input string tag, input logic exp);
    @(posedge clk);
    #1;
    checks++;
    assert (nif.spike_out === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: spike_out=%b expected %b",
             tag, nif.spike_out, exp);
    end
  endtask

  // n edges; spikes on edge first, first+period, ... (first=0: none)
  task automatic run(input string tag, input int n,
                     input int first, input int period);
    for (int i = 1; i <= n; i++) begin
      logic e;
      e = (first != 0) && (i >= first) &&
          (((i - first) % period) == 0);
      tick($sformatf("%s[%0d]", tag, i), e);
    end
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    tick(tag, 1'b0);
    reset = 1'b0;
  endtask

  task automatic set_params(input logic [7:0] th, input logic [7:0] dc,
                            input logic [7:0] rp, input logic [7:0] fb);
    nif.threshold         = th;
    nif.decay             = dc;
    nif.refractory_period = rp;
    nif.feedback_scale    = fb;
  endtask

  initial begin
    reset = 1'b1;
    nif.enable = 1'b0;
    nif.external_input_current = 8'd0;
    set_params(8'd50, 8'd10, 8'd5, 8'd20);

    do_reset("reset");
    nif.enable = 1'b1;
    run("idle", 10, 0, 1);

    nif.external_input_current = 8'd40;
    run("in40", 20, 2, 6);

    do_reset("reset2");
    nif.external_input_current = 8'd60;
    run("in60", 13, 1, 6);

    // disabled with refractory count 5 pending
    nif.enable = 1'b0;
    nif.external_input_current = 8'd80;
    run("frozen", 10, 0, 1);
    nif.enable = 1'b1;
    nif.external_input_current = 8'd90;
    run("resume", 12, 6, 6);

    do_reset("reset3");
    set_params(8'd1, 8'd255, 8'd5, 8'd80);
    nif.external_input_current = 8'd20;
    run("leak20", 5, 0, 1);
    nif.external_input_current = 8'd120;
    run("leak120", 5, 0, 1);

    do_reset("reset4");
    set_params(8'd0, 8'd10, 8'd0, 8'd20);
    nif.external_input_current = 8'd0;
    run("thr0", 4, 1, 1);

    do_reset("reset5");
    set_params(8'd50, 8'd10, 8'd5, 8'd20);
    nif.external_input_current = 8'd60;
    run("pre", 2, 1, 6);
    do_reset("midref_rst");
    nif.external_input_current = 8'd40;
    run("post", 3, 2, 6);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
